// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter funnelling N_REQ word sources into one SPI TX FIFO (SPI_TX_ARB_TAG_EN tags din[31:29] with sel).
// Latency: req seen in IDLE -> we/ack next cycle; back-to-back writes spaced gap+2 cycles.
// Backpressure: fifo_full and en gate only new grants in IDLE; an in-flight WRITE/GAP always completes.
module spi_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [GAP_W-1:0]    gap,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*32-1:0] data,
  input  logic                fifo_full,
  output logic [N_REQ-1:0]    ack,
  output logic                we,
  output logic [31:0]         din,
  output logic                tick,
  output logic                busy,
  output logic [31:0]         wr_count
);
  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, rr_ptr, pick;
  logic             pick_vld;
  logic             start;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      data_arr [N_REQ];
  logic [31:0]      din_nxt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = data[32*i +: 32];
  end

  // First requester found scanning upward from the one after the last winner.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = SEL_W'(idx);
      end
    end
  end

  assign start = en && !fifo_full && pick_vld;

`ifdef SPI_TX_ARB_TAG_EN
  assign din_nxt = {3'(pick), data_arr[pick][28:0]};
`else
  assign din_nxt = data_arr[pick];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   state_nxt = (gap != '0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we   = 1'b0;
    ack  = '0;
    tick = 1'b0;
    busy = 1'b0;
    case (state)
      WRITE: begin
        we   = 1'b1;
        ack  = N_REQ'(1) << sel;
        tick = 1'b1;
        busy = 1'b1;
      end
      GAP: begin
        tick = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Gap is sampled only in WRITE so a change mid-gap never stretches the current idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= '0;
      rr_ptr   <= SEL_W'(N_REQ - 1);
      din      <= '0;
      gap_cnt  <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel    <= pick;
          rr_ptr <= pick;
          din    <= din_nxt;
        end
        WRITE: begin
          wr_count <= wr_count + 32'd1;
          gap_cnt  <= gap;
        end
        GAP:     gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: directed stimulus pushes expected writes (requester, word, cycle)
// into a scoreboard; a negedge monitor pops and compares on every we/ack.
module tb_spi_tx_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst, en, fifo_full;
  logic [31:0]     gap;
  logic [N-1:0]    req, ack;
  logic [N*32-1:0] data;
  logic            we, tick, busy;
  logic [31:0]     din, wr_count;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          idx;
    logic [31:0] dat;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] dw [N] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hF0F0_1234, 32'hFFFF_FFFF};

`ifdef SPI_TX_ARB_TAG_EN
  localparam logic [31:0] TAG_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] TAG_EXP = 32'hFFFF_FFFF;
`endif

  spi_tx_arbiter #(.N_REQ(N), .GAP_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .gap       (gap),
    .req       (req),
    .data      (data),
    .fifo_full (fifo_full),
    .ack       (ack),
    .we        (we),
    .din       (din),
    .tick      (tick),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_din(input int idx);
    logic [31:0] w;
    w = dw[idx];
`ifdef SPI_TX_ARB_TAG_EN
    return {3'(idx), w[28:0]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] dat, input int at);
    exp_t e;
    e.idx = idx;
    e.dat = dat;
    e.at  = at;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we || (|ack)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write at cycle %0d: ack=%b din=%h, expected no write", cyc, ack, din);
      end else begin
        e = sb.pop_front();
        chk("wr_we", 32'(we), 32'd1);
        chk("wr_ack", 32'(ack), 32'(1) << e.idx);
        chk("wr_din", din, e.dat);
        chk("wr_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c, tk;
    rst = 1'b1; en = 1'b0; fifo_full = 1'b0; gap = '0; req = '0;
    for (int i = 0; i < N; i++) data[32*i +: 32] = dw[i];
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_din", din, 0);
    chk("rst_count", wr_count, 0);
    rst = 1'b0; en = 1'b1;

    // Round robin with all requesters active and no gap.
    @(negedge clk); c = cyc; gap = 0; req = 4'b1111;
    for (int i = 0; i < 5; i++) push(i % N, exp_din(i % N), c + 1 + 2*i);
    repeat (9) @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    chk("rr_count", wr_count, 5);

    // Single requester with gap=5: writes every 7 cycles, tick 6 cycles per write.
    @(negedge clk); c = cyc; gap = 5; req = 4'b0100;
    push(2, exp_din(2), c + 1); push(2, exp_din(2), c + 8); push(2, exp_din(2), c + 15);
    tk = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      tk += int'(tick);
    end
    chk("gap_tick", tk, 12);
    @(negedge clk); req = '0;
    @(negedge clk); chk("gap_busy", 32'(busy), 1);
    repeat (7) @(negedge clk); chk("gap_idle", 32'(busy), 0);
    gap = 0;

    // Backpressure: no write while fifo_full, write one cycle after release.
    @(negedge clk); c = cyc; fifo_full = 1'b1; req = 4'b0010;
    repeat (20) @(negedge clk);
    chk("bp_busy", 32'(busy), 0);
    fifo_full = 1'b0; push(1, exp_din(1), c + 21);
    @(negedge clk); req = '0;
    repeat (2) @(negedge clk);

    // Enable low blocks grants.
    @(negedge clk); c = cyc; en = 1'b0; req = 4'b0001;
    repeat (6) @(negedge clk);
    en = 1'b1; push(0, exp_din(0), c + 7);
    @(negedge clk); req = '0;
    repeat (2) @(negedge clk);

    // Tag field on requester 3 with an all-ones word.
    @(negedge clk); c = cyc; req = 4'b1000; push(3, TAG_EXP, c + 1);
    @(negedge clk); req = '0;
    repeat (2) @(negedge clk);
    chk("count_pre", wr_count, 11);

    // Counter wrap.
    @(negedge clk); force dut.wr_count = 32'hFFFF_FFFF;
    @(negedge clk); release dut.wr_count;
    chk("wrap_forced", wr_count, 32'hFFFF_FFFF);
    c = cyc; req = 4'b0001; push(0, exp_din(0), c + 1);
    @(negedge clk); req = '0;
    @(negedge clk); chk("wrap", wr_count, 0);

    // Reset in the middle of a long gap, then priority restarts at requester 0.
    repeat (2) @(negedge clk);
    @(negedge clk); c = cyc; gap = 100; req = 4'b0001; push(0, exp_din(0), c + 1);
    @(negedge clk); req = '0;
    repeat (9) @(negedge clk);
    chk("long_gap_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_count", wr_count, 0);
    rst = 1'b0; gap = 0; req = 4'b0011;
    push(0, exp_din(0), c + 12); push(1, exp_din(1), c + 14);
    repeat (3) @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    chk("post_rst_count", wr_count, 2);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter GAP_W, default 32, width of the gap configuration input.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  arbitration enable; low blocks new grants.
REQ-006 gap  input  GAP_W  minimum idle cycles inserted after each write.
REQ-007 req  input  N_REQ  per-requester write request, level.
REQ-008 data  input  N_REQ*32  per-requester word; requester i at bits [32i+31:32i].
REQ-009 fifo_full  input  1  downstream SPI FIFO cannot accept a word.
REQ-010 ack  output  N_REQ  one-hot, one-cycle pulse: requester's word consumed.
REQ-011 we  output  1  write strobe to SPI FIFO, one-cycle pulse.
REQ-012 din  output  32  word to SPI FIFO, valid when we=1.
REQ-013 tick  output  1  high in every WRITE and GAP cycle; debug pin.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 wr_count  output  32  total words written since reset.

Function
REQ-016 FSM states: IDLE, WRITE, GAP; all outputs registered or decoded from state only.
REQ-017 IDLE -> WRITE when en=1, fifo_full=0 and req!=0; otherwise remain in IDLE.
REQ-018 On the IDLE->WRITE edge: index sel latched, data[sel] latched into din, rr pointer set to sel.
REQ-019 Selection is round-robin: first set req bit searching upward from (rr pointer + 1) mod N_REQ.
REQ-020 WRITE lasts exactly one cycle: we=1, ack[sel]=1, wr_count increments by 1 (mod 2^32, wraps to 0).
REQ-021 WRITE -> GAP when gap!=0, loading gap counter with gap; WRITE -> IDLE when gap==0.
REQ-022 GAP decrements the counter each cycle; GAP -> IDLE in the cycle the counter reaches 1; gap sampled only in WRITE.
REQ-023 Latency: req seen in IDLE at cycle 0 -> we/ack at cycle 1; write-to-write spacing = gap+2 cycles.
REQ-024 fifo_full and en are sampled only in IDLE; an in-flight WRITE/GAP always completes.
REQ-025 Requester holds req and data until ack; req dropped after selection still yields the write and ack.
REQ-026 Simultaneous requests: exactly one ack per WRITE; no requester starves (service within N_REQ grants).
REQ-027 Outside WRITE: we=0, ack=0; din holds last latched word.

Reset
REQ-028 rst=1 at a rising edge forces IDLE regardless of state, aborting any pending WRITE/GAP.
REQ-029 Reset values: we=0, ack=0, tick=0, busy=0, din=0, wr_count=0, gap counter=0.
REQ-030 Reset sets rr pointer to N_REQ-1 so requester 0 has first priority.

Configuration
REQ-031 Macro SPI_TX_ARB_TAG_EN: when defined, din[31:29] = sel (3 bits, zero-extended) and din[28:0] = data[sel][28:0].
REQ-032 Without SPI_TX_ARB_TAG_EN, din = data[sel][31:0] unmodified; all other behaviour identical.

Verification
REQ-033 Reset: assert rst mid-GAP with gap=100 -> next cycle busy=0, we=0, wr_count=0; req[0]=1 next -> ack[0] after 1 cycle.
REQ-034 Round-robin: req=4'b1111, gap=0 -> ack order 0,1,2,3,0; we every 2nd cycle; din matches each data word.
REQ-035 Gap spacing: single req[2] held, gap=5 -> we pulses spaced 7 cycles; tick high 6 cycles per write.
REQ-036 Backpressure: fifo_full=1 with req[1]=1 -> no we for 20 cycles; fifo_full=0 -> we/ack[1] one cycle later.
REQ-037 Tag: SPI_TX_ARB_TAG_EN defined, req[3]=1, data[3]=32'hFFFF_FFFF -> din=32'h7FFF_FFFF; undefined -> 32'hFFFF_FFFF.
REQ-038 Wrap: force wr_count=32'hFFFF_FFFF, one write -> wr_count=0.
